// File: rtl/fft_frame_streamer.sv
// fft_frame_streamer: follows frames through the FFT pipeline latency,
// captures the 16 complex result words into a two-slot frame buffer and
// streams them out one bin per beat over valid/ready.
// Optional build macro: FFT_STREAM_SHIFT_EN (fftshift output order).
module fft_frame_streamer #(
  parameter int LATENCY = 4,
  parameter int DW      = 17,
  parameter int CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [16*DW-1:0]   fft_x,
  input  logic [16*DW-1:0]   fft_y,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DW-1:0]      m_x,
  output logic [DW-1:0]      m_y,
  output logic [3:0]         m_bin,
  output logic               m_last,
  output logic               busy,
  output logic               overflow,
  output logic [CNT_W-1:0]   drop_count
);

  // Beat index to bin index mapping.
  function automatic logic [3:0] order(input logic [3:0] b);
`ifdef FFT_STREAM_SHIFT_EN
    return b + 4'd8;
`else
    return b;
`endif
  endfunction

  logic [LATENCY-1:0] delay_line;
  logic [LATENCY-1:0] delay_next;
  logic [DW-1:0]      slot_x [2][16];
  logic [DW-1:0]      slot_y [2][16];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic [3:0]         beat;

  logic               xfer;
  logic               frame_done;
  logic               capture;
  logic               accept;
  logic               drop;
  logic [1:0]         count_next;
  logic               rd_next;
  logic [3:0]         beat_next;
  logic [3:0]         idx_next;
  logic [DW-1:0]      x_next;
  logic [DW-1:0]      y_next;

  generate
    if (LATENCY == 1) begin : g_lat1
      assign delay_next = in_valid;
    end else begin : g_latn
      assign delay_next = {delay_line[LATENCY-2:0], in_valid};
    end
  endgenerate

  // Next-state decode: handshake, capture acceptance, pointers and next beat word.
  always_comb begin
    xfer       = m_valid & m_ready;
    frame_done = xfer && (beat == 4'd15);
    capture    = delay_line[LATENCY-1];
    // A full buffer still accepts a frame when the final beat leaves this cycle.
    accept     = capture && ((count < 2'd2) || ((count == 2'd2) && frame_done));
    drop       = capture && !accept;
    case ({accept, frame_done})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
    rd_next   = frame_done ? ~rd_ptr : rd_ptr;
    beat_next = xfer ? (beat + 4'd1) : beat;
    idx_next  = order(beat_next);
    // The slot being written this cycle is not yet in the array, so bypass it.
    if (accept && (wr_ptr == rd_next)) begin
      x_next = fft_x[int'(idx_next)*DW +: DW];
      y_next = fft_y[int'(idx_next)*DW +: DW];
    end else begin
      x_next = slot_x[rd_next][idx_next];
      y_next = slot_y[rd_next][idx_next];
    end
  end

  // Frame buffer storage: write all 32 words of an accepted frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        for (int k = 0; k < 16; k++) begin
          slot_x[s][k] <= {DW{1'b0}};
          slot_y[s][k] <= {DW{1'b0}};
        end
      end
    end else if (accept) begin
      for (int k = 0; k < 16; k++) begin
        slot_x[wr_ptr][k] <= fft_x[k*DW +: DW];
        slot_y[wr_ptr][k] <= fft_y[k*DW +: DW];
      end
    end
  end

  // Control state, drop accounting and registered stream outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      delay_line <= {LATENCY{1'b0}};
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      beat       <= 4'd0;
      m_valid    <= 1'b0;
      m_x        <= {DW{1'b0}};
      m_y        <= {DW{1'b0}};
      m_bin      <= 4'd0;
      m_last     <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= {CNT_W{1'b0}};
    end else begin
      delay_line <= delay_next;
      count      <= count_next;
      rd_ptr     <= rd_next;
      beat       <= beat_next;
      if (accept) begin
        wr_ptr <= ~wr_ptr;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != {CNT_W{1'b1}}) begin
          drop_count <= drop_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      m_valid <= (count_next != 2'd0);
      busy    <= (|delay_next) || (count_next != 2'd0);
      if (count_next != 2'd0) begin
        m_x    <= x_next;
        m_y    <= y_next;
        m_bin  <= idx_next;
        m_last <= (beat_next == 4'd15);
      end else begin
        m_x    <= {DW{1'b0}};
        m_y    <= {DW{1'b0}};
        m_bin  <= 4'd0;
        m_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Directed testbench for fft_frame_streamer (LATENCY=4, DW=17, CNT_W=8).
module tb_fft_frame_streamer;
  localparam int L     = 4;
  localparam int DW    = 17;
  localparam int CNT_W = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [16*DW-1:0]  fft_x;
  logic [16*DW-1:0]  fft_y;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DW-1:0]     m_x;
  logic [DW-1:0]     m_y;
  logic [3:0]        m_bin;
  logic              m_last;
  logic              busy;
  logic              overflow;
  logic [CNT_W-1:0]  drop_count;

  int total = 0;
  int bad   = 0;

  // FFT stand-in: frame id rides a pipeline so outputs are stable at capture time.
  int fid = 0;
  int tagp [L];

  fft_frame_streamer #(.LATENCY(L), .DW(DW), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .fft_x(fft_x), .fft_y(fft_y),
    .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y),
    .m_bin(m_bin), .m_last(m_last), .busy(busy),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  // Shift frame ids through the modelled FFT latency.
  always @(posedge clock) begin
    tagp[0] <= fid;
    for (int i = 1; i < L; i++) tagp[i] <= tagp[i-1];
  end

  // Bin k of frame f carries real f*16+k and imaginary -(f*16+k).
  always @* begin
    for (int k = 0; k < 16; k++) begin
      fft_x[k*DW +: DW] = DW'(tagp[L-1]*16 + k);
      fft_y[k*DW +: DW] = DW'(-(tagp[L-1]*16 + k));
    end
  end

  function automatic int exp_bin(input int b);
`ifdef FFT_STREAM_SHIFT_EN
    return (b + 8) % 16;
`else
    return b;
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; m_ready = 1'b0; fid = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  // Launch schedule: frame sched_id[i] has in_valid at relative cycle sched_off[i].
  int sched_off [8];
  int sched_id  [8];
  int n_sched;

  task automatic launch_seq();
    int maxoff = 0;
    for (int i = 0; i < n_sched; i++) if (sched_off[i] > maxoff) maxoff = sched_off[i];
    for (int t = 0; t <= maxoff; t++) begin
      in_valid = 1'b0;
      for (int i = 0; i < n_sched; i++) begin
        if (sched_off[i] == t) begin
          in_valid = 1'b1;
          fid = sched_id[i];
        end
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Observation record filled by collect (no checking here).
  logic [DW-1:0] obs_x [64];
  logic [DW-1:0] obs_y [64];
  logic [3:0]    obs_bin [64];
  logic          obs_last [64];
  int n_beat, first_valid, first_beat, last_beat, stall_bad;

  // Drive m_ready (mode 0: always, mode 1: 1,0,0,1 pattern) from rdy_start and record beats.
  task automatic collect(input int ncyc, input int rdy_start, input int mode);
    logic pv, pr, pl;
    logic [DW-1:0] px, py;
    logic [3:0] pb;
    logic r;
    n_beat = 0; first_valid = -1; first_beat = -1; last_beat = -1; stall_bad = 0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; px = '0; py = '0; pb = '0;
    for (int t = 0; t < ncyc; t++) begin
      r = (mode == 1) ? ((t % 4 == 0) || (t % 4 == 3)) : 1'b1;
      m_ready = (t >= rdy_start) ? r : 1'b0;
      if (m_valid && first_valid < 0) first_valid = t;
      if (pv && !pr && (m_valid !== 1'b1 || m_x !== px || m_y !== py ||
                        m_bin !== pb || m_last !== pl)) stall_bad++;
      if (m_valid && m_ready && n_beat < 64) begin
        obs_x[n_beat] = m_x; obs_y[n_beat] = m_y;
        obs_bin[n_beat] = m_bin; obs_last[n_beat] = m_last;
        if (first_beat < 0) first_beat = t;
        last_beat = t;
        n_beat++;
      end
      pv = m_valid; pr = m_ready; px = m_x; py = m_y; pb = m_bin; pl = m_last;
      tick();
    end
    m_ready = 1'b0;
  endtask

  int exp_id [4];

  task automatic test_reset();
    reset = 1'b1;
    tick();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
    total++; if (m_x !== '0) begin bad++; $display("FAIL reset_m_x got=%0h want=0", m_x); end
    total++; if (m_y !== '0) begin bad++; $display("FAIL reset_m_y got=%0h want=0", m_y); end
    total++; if (m_bin !== 4'd0) begin bad++; $display("FAIL reset_m_bin got=%0d want=0", m_bin); end
    total++; if (m_last !== 1'b0) begin bad++; $display("FAIL reset_m_last got=%b want=0", m_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL reset_drop_count got=%0d want=0", drop_count); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    do_reset();
    n_sched = 1; sched_off[0] = 0; sched_id[0] = 0; exp_id[0] = 0;
    fork launch_seq(); collect(40, 0, 0); join
    total++; if (first_valid != L + 1) begin bad++; $display("FAIL single_latency got=%0d want=%0d", first_valid, L + 1); end
    total++; if (n_beat != 16) begin bad++; $display("FAIL single_beats got=%0d want=16", n_beat); end
    total++; if (last_beat - first_beat != 15) begin bad++; $display("FAIL single_contig got=%0d want=15", last_beat - first_beat); end
    for (int i = 0; i < n_beat; i++) begin
      int b, ev;
      b = exp_bin(i % 16); ev = exp_id[i / 16] * 16 + b;
      total++; if (obs_bin[i] !== 4'(b)) begin bad++; $display("FAIL single_bin[%0d] got=%0d want=%0d", i, obs_bin[i], b); end
      total++; if (obs_x[i] !== DW'(ev)) begin bad++; $display("FAIL single_x[%0d] got=%0h want=%0h", i, obs_x[i], DW'(ev)); end
      total++; if (obs_y[i] !== DW'(-ev)) begin bad++; $display("FAIL single_y[%0d] got=%0h want=%0h", i, obs_y[i], DW'(-ev)); end
      total++; if (obs_last[i] !== (i % 16 == 15)) begin bad++; $display("FAIL single_last[%0d] got=%b want=%b", i, obs_last[i], (i % 16 == 15)); end
    end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL single_end_valid got=%b want=0", m_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_end_busy got=%b want=0", busy); end
  endtask

  task automatic test_backpressure();
    do_reset();
    n_sched = 1; sched_off[0] = 0; sched_id[0] = 0; exp_id[0] = 0;
    fork launch_seq(); collect(80, 0, 1); join
    total++; if (n_beat != 16) begin bad++; $display("FAIL bp_beats got=%0d want=16", n_beat); end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_hold got=%0d want=0", stall_bad); end
    for (int i = 0; i < n_beat; i++) begin
      int b, ev;
      b = exp_bin(i % 16); ev = exp_id[i / 16] * 16 + b;
      total++; if (obs_bin[i] !== 4'(b)) begin bad++; $display("FAIL bp_bin[%0d] got=%0d want=%0d", i, obs_bin[i], b); end
      total++; if (obs_x[i] !== DW'(ev)) begin bad++; $display("FAIL bp_x[%0d] got=%0h want=%0h", i, obs_x[i], DW'(ev)); end
      total++; if (obs_last[i] !== (i % 16 == 15)) begin bad++; $display("FAIL bp_last[%0d] got=%b want=%b", i, obs_last[i], (i % 16 == 15)); end
    end
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL bp_drops got=%0d want=0", drop_count); end
  endtask

  // Three consecutive frames: the third arrives while the buffer is full mid-frame.
  task automatic test_back_to_back();
    do_reset();
    n_sched = 3;
    sched_off[0] = 0; sched_id[0] = 1;
    sched_off[1] = 1; sched_id[1] = 2;
    sched_off[2] = 2; sched_id[2] = 3;
    exp_id[0] = 1; exp_id[1] = 2;
    fork launch_seq(); collect(70, 0, 0); join
    total++; if (n_beat != 32) begin bad++; $display("FAIL b2b_beats got=%0d want=32", n_beat); end
    total++; if (last_beat - first_beat != 31) begin bad++; $display("FAIL b2b_contig got=%0d want=31", last_beat - first_beat); end
    for (int i = 0; i < n_beat && i < 32; i++) begin
      int b, ev;
      b = exp_bin(i % 16); ev = exp_id[i / 16] * 16 + b;
      total++; if (obs_x[i] !== DW'(ev)) begin bad++; $display("FAIL b2b_x[%0d] got=%0h want=%0h", i, obs_x[i], DW'(ev)); end
      total++; if (obs_y[i] !== DW'(-ev)) begin bad++; $display("FAIL b2b_y[%0d] got=%0h want=%0h", i, obs_y[i], DW'(-ev)); end
    end
    total++; if (drop_count !== 8'd1) begin bad++; $display("FAIL b2b_drops got=%0d want=1", drop_count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL b2b_overflow got=%b want=1", overflow); end
  endtask

  // Third frame captured on the exact edge the first frame's last beat leaves.
  task automatic test_simul_accept();
    do_reset();
    n_sched = 3;
    sched_off[0] = 0;  sched_id[0] = 1;
    sched_off[1] = 1;  sched_id[1] = 2;
    sched_off[2] = 16; sched_id[2] = 3;
    exp_id[0] = 1; exp_id[1] = 2; exp_id[2] = 3;
    fork launch_seq(); collect(80, 0, 0); join
    total++; if (n_beat != 48) begin bad++; $display("FAIL simul_beats got=%0d want=48", n_beat); end
    total++; if (last_beat - first_beat != 47) begin bad++; $display("FAIL simul_contig got=%0d want=47", last_beat - first_beat); end
    for (int i = 0; i < n_beat && i < 48; i++) begin
      int b, ev;
      b = exp_bin(i % 16); ev = exp_id[i / 16] * 16 + b;
      total++; if (obs_x[i] !== DW'(ev)) begin bad++; $display("FAIL simul_x[%0d] got=%0h want=%0h", i, obs_x[i], DW'(ev)); end
      total++; if (obs_last[i] !== (i % 16 == 15)) begin bad++; $display("FAIL simul_last[%0d] got=%b want=%b", i, obs_last[i], (i % 16 == 15)); end
    end
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL simul_drops got=%0d want=0", drop_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL simul_overflow got=%b want=0", overflow); end
  endtask

  task automatic test_overflow();
    do_reset();
    n_sched = 4;
    for (int i = 0; i < 4; i++) begin sched_off[i] = 2 * i; sched_id[i] = i + 1; end
    exp_id[0] = 1; exp_id[1] = 2;
    fork launch_seq(); collect(70, 20, 0); join
    total++; if (n_beat != 32) begin bad++; $display("FAIL ovf_beats got=%0d want=32", n_beat); end
    for (int i = 0; i < n_beat && i < 32; i++) begin
      int b, ev;
      b = exp_bin(i % 16); ev = exp_id[i / 16] * 16 + b;
      total++; if (obs_x[i] !== DW'(ev)) begin bad++; $display("FAIL ovf_x[%0d] got=%0h want=%0h", i, obs_x[i], DW'(ev)); end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
    total++; if (drop_count !== 8'd2) begin bad++; $display("FAIL ovf_drops got=%0d want=2", drop_count); end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    do_reset();
    n_sched = 2;
    sched_off[0] = 0;  sched_id[0] = 0;
    sched_off[1] = 10; sched_id[1] = 1;
    fork
      launch_seq();
      begin
        m_ready = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
          if (m_valid && m_bin == 4'(exp_bin(7))) found = 1'b1;
          else tick();
        end
      end
    join
    total++; if (!found) begin bad++; $display("FAIL rmid_reach_beat7 got=0 want=1"); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b want=1", busy); end
    reset = 1'b1;
    #1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", m_valid); end
    total++; if (m_bin !== 4'd0) begin bad++; $display("FAIL rmid_bin got=%0d want=0", m_bin); end
    total++; if (m_x !== '0) begin bad++; $display("FAIL rmid_x got=%0h want=0", m_x); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    tick(); tick();
    reset = 1'b0;
    collect(40, 0, 0);
    total++; if (n_beat != 0) begin bad++; $display("FAIL rmid_after_beats got=%0d want=0", n_beat); end
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL rmid_drops got=%0d want=0", drop_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy_after got=%b want=0", busy); end
  endtask

  initial begin
    for (int i = 0; i < L; i++) tagp[i] = 0;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_simul_accept();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
